hamming_receptor: RTL
=====================

Name: hamming_receptor

Overview:
- Receive side of the Hamming(7,4) link; the counterpart of the Hamming emitter.
- Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome.
- Corrects any single-bit error and delivers the 4-bit data word through a 2-stage pipeline with backpressure.
- Keeps a saturating count of codewords that needed correction, for the board status display.

Parameters:
ERR_CNT_W, 8, width of the saturating corrected-word counter (>=1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
in_code  input  7  received codeword; in_code[k] = Hamming position k+1 (p1,p2,d1,p3,d2,d3,d4)
in_valid  input  1  in_code is valid this cycle
in_ready  output  1  block can accept in_code this cycle
out_data  output  4  corrected data {d4,d3,d2,d1} = {c7,c6,c5,c3}
out_syndrome  output  3  syndrome of the word on out_data (0 = clean, else error position)
out_corrected  output  1  1 when out_syndrome != 0
out_valid  output  1  out_* fields valid
out_ready  input  1  downstream accepts out_* this cycle
clr_count  input  1  synchronous clear of err_count
err_count  output  ERR_CNT_W  number of corrected words, saturating

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0, out_data = 0, out_syndrome = 0, out_corrected = 0, err_count = 0. in_ready is combinational and reads 1 right after reset.
- Syndrome, with ci = position i:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
  - syndrome = {s3,s2,s1}; its value is the erroneous bit position 1..7.
- Correction: invert bit position `syndrome` when it is non-zero, then extract {c7,c6,c5,c3}. An error in a parity position (1, 2 or 4) leaves the data unchanged but still sets out_corrected. Double errors are out of scope: the decoder miscorrects silently, as Hamming(7,4) requires.
- Stage A register holds code, syndrome and vA. Stage B register holds data, syndrome, corrected flag and vB; Stage B drives the out_* ports and out_valid = vB.
- Handshake:
  - advB = !vB | out_ready
  - in_ready = !vA | advB (combinational, no dependency on in_valid)
  - Input transfer when in_valid & in_ready.
  - When advB: stage B loads stage A's results and vB <= vA.
  - When in_ready: stage A loads in_code and vA <= in_valid.
- Latency: a word accepted at edge N appears on out_* after edge N+1 (valid in cycle N+1). Sustained throughput is 1 word/clock when out_ready = 1.
- Backpressure: with out_ready low, out_* and out_valid stay stable until accepted. Stage A fills, and in_ready then drops after at most 1 more accepted word (2 words buffered). No word is ever lost or duplicated.
- out_valid never depends combinationally on out_ready.
- err_count increments by 1 when a word with syndrome != 0 moves from A to B (advB & vA). Each word is counted exactly once.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_count sets it to 0; clr_count beats a simultaneous increment.
- Reset mid-operation discards both buffered words immediately; no partial output follows.
- in_code is ignored when in_valid is 0. X on in_code with in_valid = 0 must not propagate to the counter.

Test Plan:
- Clean word: in_code = 7'h55 (data 4'b1011), out_ready = 1 -> two cycles later out_data = 4'b1011, out_syndrome = 0, out_corrected = 0, err_count stays 0.
- Data-bit error: in_code = 7'h45 (position 5 flipped) -> out_data = 4'b1011, out_syndrome = 3'd5, out_corrected = 1, err_count = 1.
- Parity-bit error: in_code = 7'h54 (position 1 flipped) -> out_data = 4'b1011, out_syndrome = 3'd1, err_count increments. Sweep all 16 data values x 8 error cases (none, pos 1..7) against the emitter model -> data always recovered.
- Backpressure: stream 5 words, out_ready low for 4 cycles after the first -> in_ready low after 2 buffered words, out_* held stable, all 5 delivered in order with none dropped.
- Counter saturation with ERR_CNT_W = 2: 5 erroneous words -> err_count = 3 held. clr_count asserted in the same cycle as an erroneous transfer -> err_count = 0.
- Reset mid-stream: assert rst_n low asynchronously (between edges) with both stages full -> out_valid = 0 and err_count = 0 at once. After release in_ready = 1 and the next word passes with 2-cycle latency.

Source files
------------

// File: rtl/hamming_receptor.sv
// hamming_receptor
// ----------------
// Receive side of a Hamming(7,4) link. Codewords arrive over a valid/ready
// handshake. The syndrome is computed on entry and stored in stage A. Stage A
// corrects any single-bit error and extracts the data nibble into stage B, and
// stage B drives the output handshake. A saturating counter records how many
// words needed correction.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-low
//   in_code[6:0]  received codeword, in_code[k] = Hamming position k+1
//   in_valid      in_code is valid this cycle
//   in_ready      block accepts in_code this cycle (combinational)
//   out_data[3:0] corrected data {d4,d3,d2,d1} = {c7,c6,c5,c3}
//   out_syndrome  syndrome of the word on out_data (0 = clean)
//   out_corrected 1 when out_syndrome != 0
//   out_valid     out_* fields valid
//   out_ready     downstream accepts out_* this cycle
//   clr_count     synchronous clear of err_count (beats an increment)
//   err_count     saturating count of corrected words
module hamming_receptor #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           in_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           out_data,
  output logic [2:0]           out_syndrome,
  output logic                 out_corrected,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Stage A: raw codeword and its syndrome
  logic [6:0] code_a_reg;
  logic [2:0] syn_a_reg;
  logic       valid_a_reg;

  // Stage B: corrected data presented on the outputs
  logic [3:0] data_b_reg;
  logic [2:0] syn_b_reg;
  logic       corr_b_reg;
  logic       valid_b_reg;

  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic [2:0] syn_in;
  logic [6:0] fixed_code;
  logic [3:0] data_a;
  logic       adv_b;
  logic       load_a;
  logic       count_next;

  // Syndrome over the incoming word; its value is the failing position.
  assign syn_in[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
  assign syn_in[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
  assign syn_in[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];

  // Flip the bit whose position matches the syndrome; syndrome 0 never
  // matches any position, so a clean word passes through untouched.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_fix
      assign fixed_code[gi] = code_a_reg[gi] ^ (syn_a_reg == 3'(gi + 1));
    end
  endgenerate

  assign data_a = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};

  // Stage B moves when it is empty or being drained; stage A can take a new
  // word when it is empty or its content is moving on to B.
  assign adv_b    = !valid_b_reg | out_ready;
  assign in_ready = !valid_a_reg | adv_b;
  assign load_a   = in_ready & in_valid;

  // Each erroneous word is counted once, at its A->B move.
  assign count_next = adv_b & valid_a_reg & (syn_a_reg != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_a_reg  <= '0;
      syn_a_reg   <= '0;
      valid_a_reg <= 1'b0;
    end else if (in_ready) begin
      valid_a_reg <= in_valid;
      // Payload only captured on a real transfer so idle-bus garbage
      // never reaches the syndrome or the counter.
      if (in_valid) begin
        code_a_reg <= in_code;
        syn_a_reg  <= syn_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_b_reg  <= '0;
      syn_b_reg   <= '0;
      corr_b_reg  <= 1'b0;
      valid_b_reg <= 1'b0;
    end else if (adv_b) begin
      valid_b_reg <= valid_a_reg;
      if (valid_a_reg) begin
        data_b_reg <= data_a;
        syn_b_reg  <= syn_a_reg;
        corr_b_reg <= (syn_a_reg != 3'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (clr_count) begin
      err_cnt_reg <= '0;
    end else if (count_next && !(&err_cnt_reg)) begin
      err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end
  end

  // Unused load_a kept visible for readability of the transfer condition.
  logic unused_load_a;
  assign unused_load_a = load_a;

  assign out_data      = data_b_reg;
  assign out_syndrome  = syn_b_reg;
  assign out_corrected = corr_b_reg;
  assign out_valid     = valid_b_reg;
  assign err_count     = err_cnt_reg;

endmodule
